// File: rtl/hazard_unit_pkg.sv
// Shared types and forwarding helpers for the 5-stage pipeline hazard resolver.
package hazard_unit_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        LDSTALL = 2'b01,
        DRAIN   = 2'b10,
        REDIR   = 2'b11
    } haz_state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // Memory stage wins over Writeback because it holds the younger result.
    function automatic logic [1:0] fwdSelect(
        input logic [3:0] ra,
        input logic [3:0] wa3m,
        input logic       regWriteM,
        input logic [3:0] wa3w,
        input logic       regWriteW
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (regWriteM && (ra == wa3m))
            sel = FWD_M;
        else if (regWriteW && (ra == wa3w))
            sel = FWD_W;
        return sel;
    endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset || i_clr)
            r_count <= '0;
        else if (i_inc && (r_count != '1))
            r_count <= r_count + W'(1);
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard resolver: forwarding selects, stall/flush controls, episode FSM,
// saturating performance counters and a consecutive-stall watchdog.
module hazard_unit #(
    parameter int CNT_W    = 32,
    parameter int WDOG_MAX = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       RA1E,
    input  logic [3:0]       RA2E,
    input  logic [3:0]       WA3E,
    input  logic [3:0]       WA3M,
    input  logic [3:0]       WA3W,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             IgRnE,
    input  logic             PCSrcD,
    input  logic             PCSrcE,
    input  logic             PCSrcM,
    input  logic             PCSrcW,
    input  logic             BranchTakenE,
    input  logic             CntClr,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       HazState,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt,
    output logic [CNT_W-1:0] FwdCnt,
    output logic             StallTimeout
);

    import hazard_unit_pkg::*;

    localparam int RUN_W = $clog2(WDOG_MAX + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(WDOG_MAX);

    logic       w_ldrStall;
    logic       w_pcWrPend;
    logic       w_redirect;
    haz_state_t r_state;
    haz_state_t w_nextState;

    assign w_ldrStall = MemtoRegE && ((RA1D == WA3E) || (RA2D == WA3E));
    assign w_pcWrPend = PCSrcD | PCSrcE | PCSrcM;
    assign w_redirect = BranchTakenE | PCSrcW;

    // Everything is held quiet while reset is low so no pipeline register moves.
    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        if (reset) begin
            ForwardAE = IgRnE ? FWD_RF : fwdSelect(RA1E, WA3M, RegWriteM, WA3W, RegWriteW);
            ForwardBE = fwdSelect(RA2E, WA3M, RegWriteM, WA3W, RegWriteW);
            StallD    = w_ldrStall;
            StallF    = w_ldrStall | w_pcWrPend;
            FlushD    = w_pcWrPend | PCSrcW | BranchTakenE;
            FlushE    = w_ldrStall | BranchTakenE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)
            r_state <= RUN;
        else
            r_state <= w_nextState;
    end

    // Every state leaves through the same priority ladder: LDSTALL only persists on a
    // fresh load-use, DRAIN persists while a PC write is in flight, REDIR lasts one cycle.
    always_comb begin
        w_nextState = RUN;
        if (w_redirect)
            w_nextState = REDIR;
        else if (w_pcWrPend)
            w_nextState = DRAIN;
        else if (w_ldrStall)
            w_nextState = LDSTALL;
    end

    assign HazState = r_state;

    logic w_flushInc;
    logic w_fwdInc;

    assign w_flushInc = FlushD | FlushE;
    assign w_fwdInc   = (ForwardAE != FWD_RF) | (ForwardBE != FWD_RF);

    sat_counter #(.W(CNT_W)) u_stallCnt (
        .clk(clk), .reset(reset), .i_inc(StallF), .i_clr(CntClr), .o_count(StallCnt)
    );

    sat_counter #(.W(CNT_W)) u_flushCnt (
        .clk(clk), .reset(reset), .i_inc(w_flushInc), .i_clr(CntClr), .o_count(FlushCnt)
    );

    sat_counter #(.W(CNT_W)) u_fwdCnt (
        .clk(clk), .reset(reset), .i_inc(w_fwdInc), .i_clr(CntClr), .o_count(FwdCnt)
    );

    logic [RUN_W-1:0] r_runLen;
    logic [RUN_W-1:0] w_runNext;
    logic             r_timeout;

    always_comb begin
        w_runNext = '0;
        if (StallF)
            w_runNext = (r_runLen == RUN_MAX) ? RUN_MAX : r_runLen + RUN_W'(1);
    end

    // The flag latches on the edge where the run length first reaches the limit.
    always_ff @(posedge clk) begin
        if (!reset || CntClr) begin
            r_runLen  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_runLen <= w_runNext;
            if (w_runNext == RUN_MAX)
                r_timeout <= 1'b1;
        end
    end

    assign StallTimeout = r_timeout;

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard resolver for the 5-stage ARM core. It consumes the controller's per-stage control outputs (`RegWriteM`, `RegWriteW`, `MemtoRegE`, `PCSrcD/E/M/W`, `BranchTakenE`, `IgRnE`) and datapath register addresses. It returns forwarding selects plus the stall and flush controls (`StallF`, `StallD`, `FlushD`, `FlushE`) that the controller and datapath pipeline registers use. It also tracks hazard episodes with a small state machine, saturating performance counters and a stall watchdog.

## Interface
Parameters:
- `CNT_W`, 32: width of each performance counter.
- `WDOG_MAX`, 64: maximum number of consecutive `StallF` cycles before the watchdog flag sets.

Ports:
- `clk` in 1: clock; the block has one clock.
- `reset` in 1: synchronous, active-low reset.
- `RA1D`, `RA2D` in 4: source registers in Decode.
- `RA1E`, `RA2E` in 4: source registers in Execute.
- `WA3E`, `WA3M`, `WA3W` in 4: destination registers in Execute, Memory and Writeback.
- `RegWriteM`, `RegWriteW` in 1: conditioned register-write enables.
- `MemtoRegE` in 1: the Execute-stage instruction is a load.
- `IgRnE` in 1: the Execute-stage instruction ignores Rn (operand A).
- `PCSrcD`, `PCSrcE`, `PCSrcM`, `PCSrcW` in 1: in-flight PC writes.
- `BranchTakenE` in 1: branch resolved taken.
- `CntClr` in 1: synchronous clear of all counters and the watchdog flag.
- `ForwardAE`, `ForwardBE` out 2: operand select. 00 = register file, 01 = `ResultW`, 10 = `ALUResultM`.
- `StallF`, `StallD`, `FlushD`, `FlushE` out 1: pipeline controls.
- `HazState` out 2: current episode FSM state.
- `StallCnt`, `FlushCnt`, `FwdCnt` out `CNT_W`: performance counters.
- `StallTimeout` out 1: sticky watchdog flag.

## Operation
Combinational hazard logic:
- **Forward A:**
  - `ForwardAE` = 00 if `IgRnE`.
  - Otherwise `ForwardAE` = 10 if `RegWriteM` and `RA1E==WA3M`.
  - Otherwise `ForwardAE` = 01 if `RegWriteW` and `RA1E==WA3W`.
  - Otherwise `ForwardAE` = 00.
  - The Memory stage has priority over Writeback.
- **Forward B:** same rule using `RA2E`, without the `IgRnE` term.
- **ldrStall:** `MemtoRegE` and (`RA1D==WA3E` or `RA2D==WA3E`).
- **PCWrPend:** `PCSrcD | PCSrcE | PCSrcM`.
- **Outputs:**
  - `StallD` = `ldrStall`.
  - `StallF` = `ldrStall | PCWrPend`.
  - `FlushD` = `PCWrPend | PCSrcW | BranchTakenE`.
  - `FlushE` = `ldrStall | BranchTakenE`.
- **While `reset` is low:** all stall/flush outputs are 0 and `ForwardAE`/`ForwardBE` are 00.

Episode FSM (`HazState`), evaluated each cycle in priority order:
- **`RUN` (00):** go to `REDIR` if `BranchTakenE` or `PCSrcW`. Otherwise go to `DRAIN` if `PCWrPend`. Otherwise go to `LDSTALL` if `ldrStall`.
- **`LDSTALL` (01):** return to `RUN` the next cycle. A load stall lasts exactly 1 cycle because the load has moved to Memory. If `ldrStall` is asserted again, remain in `LDSTALL`.
- **`DRAIN` (10):** remain while `PCWrPend`. On `PCSrcW` go to `REDIR`.
- **`REDIR` (11):** return to `RUN` the next cycle unless `BranchTakenE`, `PCSrcW` or `PCWrPend` is asserted; apply the `RUN` priorities in that case.

Counters:
- `StallCnt` increments each cycle `StallF` is high.
- `FlushCnt` increments each cycle `FlushD` or `FlushE` is high.
- `FwdCnt` increments each cycle `ForwardAE`≠00 or `ForwardBE`≠00. The increment is 1 per cycle, even if both selects are non-zero.
- All counters saturate at all-ones; they never wrap.
- `CntClr` takes precedence over an increment in the same cycle.

Watchdog:
- An internal run-length counter, `$clog2(WDOG_MAX+1)` bits wide, counts consecutive `StallF` cycles.
- The counter resets to 0 on any cycle with `StallF` low.
- `StallTimeout` sets when the run length reaches `WDOG_MAX`.
- The flag is sticky until `reset` or `CntClr`.

## Timing
- Hazard outputs are combinational, with zero latency from their inputs.
- The FSM, counters and watchdog update on the `clk` rising edge and reflect the previous cycle's conditions.
- Reset values: `HazState` = `RUN`; all counters = 0; `StallTimeout` = 0; run length = 0.
- A reset asserted mid-episode returns the block to `RUN` at the next edge, regardless of inputs.
- Simultaneous `ldrStall` and `BranchTakenE`: both take effect, so `StallF`, `StallD`, `FlushD` and `FlushE` are all 1. The FSM goes to `REDIR`.
- Simultaneous `CntClr` and `StallTimeout` set condition: clear wins, and the run length also clears.

## Structure
- A shared package holds `haz_state_t` (`RUN`, `LDSTALL`, `DRAIN`, `REDIR`) and the forward-select constants `FWD_RF`, `FWD_W`, `FWD_M`.
- One sub-module, `sat_counter` (parameterised width, with increment and clear inputs), is instantiated three times.

## Test plan
- **Memory-stage forwarding:** `RA1E`=3, `WA3M`=3, `RegWriteM`=1, `WA3W`=3, `RegWriteW`=1 → `ForwardAE`=10. With `IgRnE`=1 → `ForwardAE`=00. `FwdCnt` increments by 1 only when a select is non-zero.
- **Load-use stall:** `MemtoRegE`=1, `WA3E`=5, `RA2D`=5 → `StallF`=`StallD`=`FlushE`=1 and `FlushD`=0. `HazState` goes `RUN`→`LDSTALL`→`RUN`. `StallCnt`=1.
- **PC-write drain:** `PCSrcD` pulse propagated through `PCSrcE`/`PCSrcM`/`PCSrcW` → `StallF`=1 for 3 cycles and `FlushD`=1 for 4 cycles. `HazState` sequence: `DRAIN`,`DRAIN`,`DRAIN`,`REDIR`,`RUN`.
- **Simultaneous load stall and taken branch:** `ldrStall` and `BranchTakenE` in the same cycle → all four controls = 1. Next state = `REDIR`. `FlushCnt` increments by 1.
- **Watchdog:** with `WDOG_MAX`=4, hold `PCSrcE`=1 for 4 cycles → `StallTimeout`=1 after the 4th edge and stays set after `PCSrcE` drops. `CntClr`=1 → `StallTimeout` and all counters = 0 the next cycle.
- **Saturation and reset:** with `CNT_W`=4, 20 stall cycles → `StallCnt`=15. Then `reset`=0 mid-`DRAIN` → `HazState`=`RUN`, counters = 0, all outputs forced 0 while reset is held.
